// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler
// Round-robin scheduler that owns the select lines of a shared single-bit
// 8:1 multiplexer. Eight level-sensitive requesters share the mux. Each
// grant lasts for a bounded burst of BURST_LEN cycles, and the routed bit
// appears on y.
// Optional feature: define MUX8_SCHED_LOCK_EN to add a 'lock' input. While
// lock is high it extends the current burst past BURST_LEN.

// ---------------------------------------------------------------------------
// Cyclic first-set search: nearest set bit of vec at or after 'start',
// wrapping 7 -> 0.
// ---------------------------------------------------------------------------
module mux8_rr_pick (
    input  logic [7:0] vec,
    input  logic [2:0] start,
    output logic       any,
    output logic [2:0] idx
);
    logic [7:0] rot;
    logic [2:0] off;

    // rotate so that position 0 of rot corresponds to 'start'
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot[gi] = vec[start + 3'(gi)];
        end
    endgenerate

    // lowest set bit of the rotated vector is the nearest requester
    always_comb begin
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
    end

    assign any = |vec;
    assign idx = start + off;
endmodule

// ---------------------------------------------------------------------------
// Single-bit 8:1 multiplexer with individual select lines s2/s1/s0.
// ---------------------------------------------------------------------------
module mux8_rr_mux (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic s2,
    input  logic s1,
    input  logic s0,
    output logic y
);
    // pure combinational selection of one input
    always_comb begin
        case ({s2, s1, s0})
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            default: y = i7;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// Scheduler top level
// ---------------------------------------------------------------------------
module mux8_rr_scheduler #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
`ifdef MUX8_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // last count value of a burst; cnt never goes past this
    localparam logic [3:0] CNT_MAX = 4'(BURST_LEN - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] cnt;

    logic       lock_hold;
    logic [7:0] owner_bit;
    logic       req_owner;
    logic       burst_done;
    logic       release_now;
    logic [7:0] pick_vec;
    logic       pick_any;
    logic [2:0] pick_idx;
    logic       do_load;
    logic       do_idle;
    logic [2:0] load_idx;
    logic       mux_y;

`ifdef MUX8_SCHED_LOCK_EN
    // lock only matters in GRANT, and release logic is only evaluated there
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign owner_bit   = 8'd1 << sel;
    assign req_owner   = req[sel];
    assign burst_done  = (cnt == CNT_MAX) && !lock_hold;
    assign release_now = (state == GRANT) && (!req_owner || burst_done);

    // On release, the current owner is excluded from the search so that others get a turn.
    // ptr already points one past the owner.
    assign pick_vec = (state == GRANT) ? (req & ~owner_bit) : req;

    mux8_rr_pick u_pick (
        .vec   (pick_vec),
        .start (ptr),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // decide whether this edge loads a new grant, goes idle, or just counts
    always_comb begin
        do_load  = 1'b0;
        do_idle  = 1'b0;
        load_idx = pick_idx;
        case (state)
            IDLE: begin
                do_load = pick_any;
            end
            GRANT: begin
                if (release_now) begin
                    if (pick_any) begin
                        do_load = 1'b1;
                    end else if (req_owner) begin
                        // nobody else waiting: owner starts a fresh burst
                        do_load  = 1'b1;
                        load_idx = sel;
                    end else begin
                        do_idle = 1'b1;
                    end
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase
    end

    // scheduler state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
            sel   <= 3'd0;
            gnt   <= 8'h00;
            busy  <= 1'b0;
        end else if (do_load) begin
            state <= GRANT;
            sel   <= load_idx;
            gnt   <= 8'd1 << load_idx;
            busy  <= 1'b1;
            cnt   <= 4'd0;
            ptr   <= load_idx + 3'd1;
        end else if (do_idle) begin
            // sel keeps its last value while idle
            state <= IDLE;
            gnt   <= 8'h00;
            busy  <= 1'b0;
            cnt   <= 4'd0;
        end else if ((state == GRANT) && (cnt != CNT_MAX)) begin
            // saturates at CNT_MAX when a lock holds the burst open
            cnt <= cnt + 4'd1;
        end
    end

    mux8_rr_mux u_mux (
        .i0 (din[0]),
        .i1 (din[1]),
        .i2 (din[2]),
        .i3 (din[3]),
        .i4 (din[4]),
        .i5 (din[5]),
        .i6 (din[6]),
        .i7 (din[7]),
        .s2 (sel[2]),
        .s1 (sel[1]),
        .s0 (sel[0]),
        .y  (mux_y)
    );

    // the routed bit is forced low whenever no grant is active
    assign y = busy & mux_y;
endmodule

// File: doc/mux8_rr_scheduler.md
# mux8_rr_scheduler

Round-robin scheduler that shares the team's single-bit 8:1 multiplexer between eight requesters. It arbitrates `req[7:0]` and holds each grant for a bounded burst. It drives the mux select lines (`s2`, `s1`, `s0`) as `sel[2:0]` and presents the routed bit on `y`. It sits directly in front of the 8:1 mux instance and owns its select inputs; no other logic may drive them.

## Interface

Parameters:
- `BURST_LEN`, default 4: maximum consecutive cycles per grant; legal range 1..16.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `req`  input  8  request vector; bit n is requester n; level-sensitive.
- `din`  input  8  data bit per requester; these are the mux inputs i0..i7.
- `lock` input  1  burst extension; present only when `MUX8_SCHED_LOCK_EN` is defined.
- `gnt`  output 8  one-hot grant, registered; all zero when idle.
- `sel`  output 3  mux select, registered; `sel[2]`=s2, `sel[1]`=s1, `sel[0]`=s0.
- `busy` output 1  grant active, registered.
- `y`    output 1  routed bit: `din[sel]` when `busy`=1, else 0; combinational through the 8:1 mux.

## Operation

- **Reset values:** `gnt`=8'h00, `sel`=3'd0, `busy`=0, `y`=0, state=IDLE, round-robin pointer `ptr`=3'd0, burst counter `cnt`=0.
- **States:**
  - IDLE:
    - If `req`==0, stay in IDLE.
    - Otherwise, go to GRANT with the winner.
  - GRANT:
    - The owner is index `sel`.
    - `cnt` increments every cycle.
- **Winner search:** pick the first set bit of `req`, scanning cyclically from `ptr` upward: `ptr`, `ptr`+1, …, 7, 0, …, `ptr`-1.
- **Loading a grant:** on grant, load `sel`=winner, `gnt`=1<<winner, `busy`=1, `cnt`=0, `ptr`=winner+1 (mod 8, wraps 7→0).
- **Release condition**, evaluated in GRANT: `req[sel]`==0, or `cnt`==`BURST_LEN`-1.
- **On release:**
  - If `req` masked with the owner's own bit cleared is nonzero, grant the next winner in the same edge (back-to-back, no idle cycle). The search starts at the updated `ptr`.
  - If that masked vector is zero but the owner's request is still asserted, re-grant the owner and reset `cnt`=0.
  - If `req`==0, go to IDLE: `gnt`=0, `busy`=0. `sel` holds its last value.
- **Fairness:** with all eight requesting continuously, the grant order is 0,1,…,7,0,… with exactly `BURST_LEN` cycles each.
- **Counter width:** `cnt` is 4 bits; it never exceeds `BURST_LEN`-1, so it cannot overflow.
- **Mid-burst changes:** a requester raising `req` during another's burst waits; it is never preempted into the current burst.
- **Reset mid-burst:** all state returns to reset values immediately (asynchronous), and `y` drops to 0 in the same cycle.

## Timing

- **Grant latency:** `req` sampled at edge k gives `gnt`/`sel`/`busy` valid after edge k; `y` is valid in that same cycle after combinational mux delay.
- **Burst duration:** a full burst keeps `busy` high for exactly `BURST_LEN` cycles per owner.
- **Early release:** if the owner deasserts `req` in cycle c, the grant drops or moves at the edge ending cycle c.
- **Switch timing:** `gnt`, `sel` and `busy` change only on clock edges, except on reset assertion.
- **One-hot invariant:** `gnt` is always one-hot or zero, and `gnt`==(`busy` ? 1<<`sel` : 0).
- **Req-to-grant bound:** any continuously asserted `req` is granted within 7×`BURST_LEN`+1 cycles.

## Configuration

- **Macro:** `MUX8_SCHED_LOCK_EN`.
- **Defined:**
  - The `lock` input exists.
  - While `busy`=1 and `lock`=1, the burst-limit release is suppressed and `cnt` saturates at `BURST_LEN`-1.
  - Release then occurs only when `req[sel]` falls, or at the first edge where `lock`=0 and `cnt`==`BURST_LEN`-1.
  - `lock` is ignored while IDLE.
- **Undefined:** there is no `lock` port and bursts are always bounded by `BURST_LEN`.

## Test plan

- **Reset:** assert `rst` mid-burst with `req`=8'hFF → `gnt`=0, `sel`=0, `busy`=0, `y`=0 immediately. After release, the first grant is to requester 0.
- **Full contention:** `BURST_LEN`=4, `req`=8'hFF held for 40 cycles → `sel` sequence 0,0,0,0,1,1,1,1,…,7,7,7,7,0…. No idle gaps; `gnt` matches `sel`.
- **Early release and wrap:**
  - Setup: `req`=8'b1000_0010, with requester 7 holding the grant (ptr=0).
  - Stimulus: drop `req[7]` after 2 cycles.
  - Expect: the grant moves to 1 on the next edge, and `ptr` wraps to 0 during the search.
- **Data routing:** while granted to 5, toggle `din[5]` 0/1/0 and keep the other bits opposite → `y` follows `din[5]` each cycle. With `req`=0 → `busy`=0 and `y`=0 regardless of `din`.
- **Sole requester:** `req`=8'h08 continuous → `sel`=3, `busy` stays 1 across burst boundaries, and `cnt` resets every 4 cycles with no gap.
- **Lock (`MUX8_SCHED_LOCK_EN` defined):**
  - Stimulus: `req`=8'h03, requester 0 granted, `lock`=1 for 10 cycles.
  - Expect: requester 0 holds for 10 cycles. After `lock` falls, the grant moves to 1 at the next edge.
